// File: rtl/mode_sequencer_pkg.sv
// Shared definitions for the mode sequencer.
// Holds the slot count, the slot index width, the FSM state encoding, the
// SLOT1..SLOT5 mode constants and a helper that turns a one-hot switch
// pattern into a slot index.
package mode_sequencer_pkg;

    localparam int NUM_SLOTS = 5;
    localparam int SLOT_W    = 3;

    typedef logic [SLOT_W-1:0] slot_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        BLANK     = 3'd1,
        RECONF    = 3'd2,
        LOCK_WAIT = 3'd3,
        SETTLE    = 3'd4
    } state_t;

    // SLOT1 is the mode selected by switch bit 0, SLOT5 by switch bit 4.
    localparam slot_t SLOT1 = 3'd0;
    localparam slot_t SLOT2 = 3'd1;
    localparam slot_t SLOT3 = 3'd2;
    localparam slot_t SLOT4 = 3'd3;
    localparam slot_t SLOT5 = 3'd4;

    // Only meaningful for one-hot input; the highest set bit wins otherwise.
    function automatic slot_t onehot_to_slot(input logic [NUM_SLOTS-1:0] pattern);
        slot_t idx;
        idx = SLOT1;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (pattern[i]) begin
                idx = slot_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mode_sequencer_switch_debounce.sv
// Synchronizer plus one-hot debouncer for the slot switches.
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   switch_in    raw asynchronous one-hot slot switches
//   accept       one-cycle pulse when a pattern has been stable long enough
//   accept_slot  slot index of the accepted pattern, valid with accept
module switch_debounce
    import mode_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_SLOTS-1:0] switch_in,
    output logic                 accept,
    output logic [SLOT_W-1:0]    accept_slot
);

    localparam int            CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] TARGET = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic [NUM_SLOTS-1:0] sync_meta;
    logic [NUM_SLOTS-1:0] sync_out;
    logic [NUM_SLOTS-1:0] prev_pattern;
    logic [CW-1:0]        run_cnt;
    logic [CW-1:0]        run_next;
    logic                 is_onehot;
    logic                 same_run;
    logic                 fire;

    // run_next is the length of the current run of one identical one-hot
    // pattern, including this cycle; it saturates at TARGET so a held
    // switch produces exactly one accept pulse.
    always_comb begin
        is_onehot = $onehot(sync_out);
        same_run  = is_onehot && (sync_out == prev_pattern) && (run_cnt != '0);
        run_next  = '0;
        if (same_run) begin
            run_next = (run_cnt == TARGET) ? TARGET : run_cnt + ONE;
        end else if (is_onehot) begin
            run_next = ONE;
        end
        fire = (run_next == TARGET) && !(same_run && (run_cnt == TARGET));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta    <= '0;
            sync_out     <= '0;
            prev_pattern <= '0;
            run_cnt      <= '0;
            accept       <= 1'b0;
            accept_slot  <= SLOT1;
        end else begin
            sync_meta    <= switch_in;
            sync_out     <= sync_meta;
            prev_pattern <= sync_out;
            run_cnt      <= run_next;
            accept       <= fire;
            if (fire) begin
                accept_slot <= onehot_to_slot(sync_out);
            end
        end
    end

endmodule

// File: rtl/mode_sequencer.sv
// Video mode sequencer.
// Debounces the one-hot slot switches, then walks the video PLL through
// blank -> reconfigure -> wait-for-lock -> settle whenever the requested slot
// differs from the active one. At reset release it configures slot 0.
// Ports:
//   clock            system clock, rising edge
//   reset_n          asynchronous active-low reset
//   switch_in        raw one-hot slot switches
//   pll_reconf_req   level request to the PLL reconfiguration engine
//   pll_reconf_slot  slot to configure, valid while pll_reconf_req is high
//   pll_reconf_ack   engine reports reconfiguration complete
//   pll_locked       asynchronous PLL lock indicator
//   mode_sel         active slot driven to the video pipeline
//   video_enable     video output enable, high only while idle
//   config_changed   one-cycle pulse when a new mode becomes active
//   retry_count      saturating number of lock timeouts since reset
module mode_sequencer
    import mode_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLANK_CYCLES    = 1024,
    parameter int LOCK_STABLE     = 4096,
    parameter int LOCK_TIMEOUT    = 2000000
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_SLOTS-1:0] switch_in,
    output logic                 pll_reconf_req,
    output logic [SLOT_W-1:0]    pll_reconf_slot,
    input  logic                 pll_reconf_ack,
    input  logic                 pll_locked,
    output logic [SLOT_W-1:0]    mode_sel,
    output logic                 video_enable,
    output logic                 config_changed,
    output logic [3:0]           retry_count
);

    localparam int            BW         = $clog2(BLANK_CYCLES + 1);
    localparam int            LW         = $clog2(LOCK_STABLE + 1);
    localparam int            TW         = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_STABLE - 1);
    localparam logic [TW-1:0] TOUT_LAST  = TW'(LOCK_TIMEOUT - 1);

    state_t          state;
    slot_t           pending_slot;
    slot_t           target;
    logic            accept;
    slot_t           accept_slot;
    logic            lock_meta;
    logic            lock_sync;
    logic [BW-1:0]   blank_cnt;
    logic [LW-1:0]   lock_cnt;
    logic [TW-1:0]   timeout_cnt;

    switch_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_switch_debounce (
        .clock      (clock),
        .reset_n    (reset_n),
        .switch_in  (switch_in),
        .accept     (accept),
        .accept_slot(accept_slot)
    );

    assign pll_reconf_slot = target;

    // Lock synchronizer and the pending request register. pending_slot is
    // simply overwritten by every acceptance; the FSM only looks at it from
    // IDLE, so a change arriving mid-sequence waits for the next pass.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta    <= 1'b0;
            lock_sync    <= 1'b0;
            pending_slot <= SLOT1;
        end else begin
            lock_meta <= pll_locked;
            lock_sync <= lock_meta;
            if (accept) begin
                pending_slot <= accept_slot;
            end
        end
    end

    // Sequencing FSM. Reset lands in RECONF with target 0 so the PLL is
    // programmed for slot 0 at power-up. All outputs are registered, so the
    // SETTLE assignments become visible as the FSM reaches IDLE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= RECONF;
            target         <= SLOT1;
            mode_sel       <= SLOT1;
            video_enable   <= 1'b0;
            pll_reconf_req <= 1'b0;
            config_changed <= 1'b0;
            retry_count    <= '0;
            blank_cnt      <= '0;
            lock_cnt       <= '0;
            timeout_cnt    <= '0;
        end else begin
            config_changed <= 1'b0;
            case (state)
                IDLE: begin
                    if (pending_slot != mode_sel) begin
                        target       <= pending_slot;
                        video_enable <= 1'b0;
                        blank_cnt    <= '0;
                        state        <= BLANK;
                    end
                end
                BLANK: begin
                    if (blank_cnt == BLANK_LAST) begin
                        blank_cnt <= '0;
                        state     <= RECONF;
                    end else begin
                        blank_cnt <= blank_cnt + 1'b1;
                    end
                end
                RECONF: begin
                    // The ack only counts while the request is up.
                    if (pll_reconf_req && pll_reconf_ack) begin
                        pll_reconf_req <= 1'b0;
                        lock_cnt       <= '0;
                        timeout_cnt    <= '0;
                        state          <= LOCK_WAIT;
                    end else begin
                        pll_reconf_req <= 1'b1;
                    end
                end
                LOCK_WAIT: begin
                    if (lock_sync && (lock_cnt == LOCK_LAST)) begin
                        state <= SETTLE;
                    end else if (timeout_cnt == TOUT_LAST) begin
                        if (retry_count != 4'hF) begin
                            retry_count <= retry_count + 1'b1;
                        end
                        state <= RECONF;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                        lock_cnt    <= lock_sync ? lock_cnt + 1'b1 : '0;
                    end
                end
                SETTLE: begin
                    mode_sel       <= target;
                    video_enable   <= 1'b1;
                    config_changed <= 1'b1;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
